// File: rtl/lebug_pkg.sv
// Shared definitions for the vector trace pipeline: firmware opcodes and chain-id sizing.
package lebug_pkg;

  localparam logic [7:0] FW_PASS = 8'd0;
  localparam logic [7:0] FW_PACK = 8'd1;

  // A single chain still needs a one-bit id port.
  function automatic int unsigned chain_id_width(input int unsigned max_chains);
    return (max_chains > 1) ? $clog2(max_chains) : 1;
  endfunction

endpackage

// File: rtl/pack_lane_buffer.sv
// Per-chain pack buffer: collects lane-0 scalars into a dense N-lane vector.
// vec_o/count_o/full_o show the buffer as it would be after this cycle's write.
module pack_lane_buffer #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned CntW      = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_i,
  input  logic [DATA_WIDTH-1:0]   scalar_i,
  input  logic                    flush_i,
  input  logic                    clear_i,
  output logic [N*DATA_WIDTH-1:0] vec_o,
  output logic [CntW-1:0]         count_o,
  output logic                    full_o
);

  logic [N*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [CntW-1:0]         count_q, count_d;

  always_comb begin
    vec_o = buf_q;
    for (int i = 0; i < N; i++) begin
      if (write_i && (count_q == CntW'(i))) begin
        vec_o[i*DATA_WIDTH +: DATA_WIDTH] = scalar_i;
      end
    end
    count_o = count_q + CntW'(write_i);
    full_o  = (count_o == CntW'(N));
  end

  // The owner flushes on full, so count never rests at N.
  always_comb begin
    buf_d   = vec_o;
    count_d = count_o;
    if (flush_i || clear_i) begin
      buf_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/data_packing_unit.sv
// Packs per-chain lane-0 scalars into dense vectors ahead of the trace buffer.
// Define DATA_PACKING_OCCUPANCY_EN to add the lanes_valid_out occupancy port.
module data_packing_unit
  import lebug_pkg::*;
#(
  parameter int unsigned             N                  = 8,
  parameter int unsigned             DATA_WIDTH         = 32,
  parameter int unsigned             MAX_CHAINS         = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE   = '0,
  localparam int unsigned            ChainW             = chain_id_width(MAX_CHAINS),
  localparam int unsigned            CntW               = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic                    eof_in,
  input  logic [ChainW-1:0]       chainId_in,
  input  logic                    tracing,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  output logic                    valid_out,
  output logic [N*DATA_WIDTH-1:0] vector_out,
`ifdef DATA_PACKING_OCCUPANCY_EN
  output logic [CntW-1:0]         lanes_valid_out,
`endif
  output logic                    eof_out,
  output logic [ChainW-1:0]       chainId_out
);

  logic [7:0]              firmware_q [MAX_CHAINS];
  logic [7:0]              firmware_d [MAX_CHAINS];
  logic [N*DATA_WIDTH-1:0] buf_vec    [MAX_CHAINS];
  logic [CntW-1:0]         buf_cnt    [MAX_CHAINS];
  logic [MAX_CHAINS-1:0]   buf_full, buf_wr, buf_flush, buf_clear;

  logic              chain_ok, pack_sel, emit_pack, cfg_wr;
  logic [ChainW-1:0] sel;

  logic                    valid_q, valid_d;
  logic [N*DATA_WIDTH-1:0] vector_q, vector_d;
  logic                    eof_q, eof_d;
  logic [ChainW-1:0]       chain_q, chain_d;

  always_comb begin
    chain_ok  = (32'(chainId_in) < MAX_CHAINS);
    sel       = chain_ok ? chainId_in : '0;
    pack_sel  = (firmware_q[sel] == FW_PACK);
    cfg_wr    = !tracing && chain_ok && (configId == PERSONAL_CONFIG_ID);
    // buf_cnt already includes a same-cycle scalar, so eof can flush it too.
    emit_pack = tracing && chain_ok && pack_sel &&
                (buf_full[sel] || (eof_in && (buf_cnt[sel] != '0)));
    for (int c = 0; c < MAX_CHAINS; c++) begin
      buf_wr[c]    = tracing && valid_in && chain_ok && pack_sel && (sel == ChainW'(c));
      buf_flush[c] = emit_pack && (sel == ChainW'(c));
      buf_clear[c] = cfg_wr && (sel == ChainW'(c));
    end
  end

  for (genvar c = 0; c < MAX_CHAINS; c++) begin : g_chain
    pack_lane_buffer #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .write_i  (buf_wr[c]),
      .scalar_i (vector_in[DATA_WIDTH-1:0]),
      .flush_i  (buf_flush[c]),
      .clear_i  (buf_clear[c]),
      .vec_o    (buf_vec[c]),
      .count_o  (buf_cnt[c]),
      .full_o   (buf_full[c])
    );
  end

  always_comb begin
    for (int c = 0; c < MAX_CHAINS; c++) begin
      firmware_d[c] = firmware_q[c];
    end
    if (cfg_wr) begin
      firmware_d[sel] = configData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        firmware_q[c] <= INITIAL_FIRMWARE[c*8 +: 8];
      end
    end else begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        firmware_q[c] <= firmware_d[c];
      end
    end
  end

  // Unknown firmware values fall through to pass-through.
  always_comb begin
    valid_d  = 1'b0;
    vector_d = vector_q;
    eof_d    = eof_in;
    chain_d  = chainId_in;
    if (tracing && chain_ok) begin
      if (pack_sel) begin
        if (emit_pack) begin
          valid_d  = 1'b1;
          vector_d = buf_vec[sel];
        end
      end else if (valid_in) begin
        valid_d  = 1'b1;
        vector_d = vector_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      vector_q <= '0;
      eof_q    <= 1'b0;
      chain_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      vector_q <= vector_d;
      eof_q    <= eof_d;
      chain_q  <= chain_d;
    end
  end

`ifdef DATA_PACKING_OCCUPANCY_EN
  logic [CntW-1:0] lanes_q, lanes_d;

  always_comb begin
    lanes_d = '0;
    if (valid_d) begin
      lanes_d = pack_sel ? buf_cnt[sel] : CntW'(N);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_q <= '0;
    end else begin
      lanes_q <= lanes_d;
    end
  end

  assign lanes_valid_out = lanes_q;
`endif

  assign valid_out   = valid_q;
  assign vector_out  = vector_q;
  assign eof_out     = eof_q;
  assign chainId_out = chain_q;

endmodule

// File: tb/tb_data_packing_unit.sv
// Randomized bench for data_packing_unit against a queue-based packing model.
module tb_data_packing_unit;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid_in = 1'b0;
  logic         eof_in = 1'b0;
  logic [1:0]   chainId_in = '0;
  logic         tracing = 1'b0;
  logic [7:0]   configId = '0;
  logic [7:0]   configData = '0;
  logic [255:0] vector_in = '0;
  logic         valid_out;
  logic [255:0] vector_out;
  logic         eof_out;
  logic [1:0]   chainId_out;
`ifdef DATA_PACKING_OCCUPANCY_EN
  logic [3:0]   lanes_valid_out;
`endif

  data_packing_unit dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .eof_in     (eof_in),
    .chainId_in (chainId_in),
    .tracing    (tracing),
    .configId   (configId),
    .configData (configData),
    .vector_in  (vector_in),
    .valid_out  (valid_out),
    .vector_out (vector_out),
`ifdef DATA_PACKING_OCCUPANCY_EN
    .lanes_valid_out (lanes_valid_out),
`endif
    .eof_out    (eof_out),
    .chainId_out(chainId_out)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model state: firmware byte and the list of scalars waiting per chain.
  logic [7:0]  mfw [4];
  logic [31:0] mq  [4][$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic e, input logic [1:0] ch,
                      input logic tr, input logic [7:0] cid, input logic [7:0] cd,
                      input logic [255:0] vec);
    logic         exp_valid, exp_eof, chk_vec;
    logic [1:0]   exp_ch;
    logic [255:0] exp_vec;
    int           exp_lanes;
    reset = r; valid_in = v; eof_in = e; chainId_in = ch; tracing = tr;
    configId = cid; configData = cd; vector_in = vec;

    exp_valid = 1'b0; exp_eof = r ? 1'b0 : e; exp_ch = r ? 2'd0 : ch;
    exp_vec = '0; chk_vec = 1'b0; exp_lanes = 0;
    if (r) begin
      for (int c = 0; c < 4; c++) begin
        mq[c].delete();
        mfw[c] = 8'd0;
      end
      chk_vec = 1'b1;
    end else if (!tr) begin
      if (cid == 8'd0) begin
        mfw[ch] = cd;
        mq[ch].delete();
      end
    end else if (mfw[ch] == 8'd1) begin
      if (v) mq[ch].push_back(vec[31:0]);
      if (mq[ch].size() == 8 || (e && mq[ch].size() > 0)) begin
        for (int i = 0; i < mq[ch].size(); i++) exp_vec[i*32 +: 32] = mq[ch][i];
        exp_valid = 1'b1;
        chk_vec   = 1'b1;
        exp_lanes = mq[ch].size();
        mq[ch].delete();
      end
    end else if (v) begin
      exp_valid = 1'b1;
      chk_vec   = 1'b1;
      exp_vec   = vec;
      exp_lanes = 8;
    end

    @(posedge clk);
    #1;
    check("valid_out", 256'(valid_out), 256'(exp_valid));
    check("eof_out", 256'(eof_out), 256'(exp_eof));
    check("chainId_out", 256'(chainId_out), 256'(exp_ch));
    if (chk_vec) check("vector_out", vector_out, exp_vec);
`ifdef DATA_PACKING_OCCUPANCY_EN
    check("lanes_valid_out", 256'(lanes_valid_out), 256'(exp_lanes));
`endif
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] v;

    step(1, 0, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, 0, '0);

    // Pass-through on chain 0.
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(i + 1);
    step(0, 1, 0, 0, 1, 0, 0, v);

    // Full pack on chain 1.
    step(0, 0, 0, 1, 0, 8'd0, 8'd1, '0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 1, 0, 0, 256'(10 + i) | (rand_vec() << 32));

    // Eof flush of a partial buffer.
    for (int i = 5; i < 8; i++) step(0, 1, 0, 1, 1, 0, 0, 256'(i));
    step(0, 0, 1, 1, 1, 0, 0, '0);

    // Interleaved chains 0 and 1.
    step(0, 0, 0, 0, 0, 8'd0, 8'd1, '0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 2'(i % 2), 1, 0, 0, 256'(100 + i));

    // Reset mid-pack, then eof and firmware check via pass-through.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 1, 0, 0, 256'(50 + i));
    step(1, 0, 0, 0, 1, 0, 0, '0);
    step(0, 0, 1, 1, 1, 0, 0, '0);
    step(0, 1, 0, 1, 1, 0, 0, rand_vec());

    // Eighth scalar together with eof.
    step(0, 0, 0, 1, 0, 8'd0, 8'd1, '0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 1, 0, 0, 256'(20 + i));
    step(0, 1, 1, 1, 1, 0, 0, 256'(27));
    step(0, 0, 1, 1, 1, 0, 0, '0);

    // Config write to another block's id must be ignored.
    step(0, 0, 0, 2, 0, 8'd1, 8'd1, '0);
    step(0, 1, 0, 2, 1, 0, 0, rand_vec());

    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 100) == 0, ($urandom % 10) < 7, ($urandom % 8) == 0,
           2'($urandom_range(0, 3)), ($urandom % 10) != 0,
           (($urandom % 4) == 0) ? 8'd1 : 8'd0, 8'($urandom_range(0, 3)), rand_vec());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
